nano_mem_arbiter: RTL and testbench
===================================

// Module: nano_mem_arbiter
// PURPOSE
//  Shares the single-port 256x16 program/data memory between two requesters:
//  port A (NanoCPU) and port B (loader/debug/DMA master).
//  Sits between the masters and the memory array; owns the memory ce/we/address/dataW lines.
//  Round-robin arbitration with a bounded burst lock, so neither master starves.
// PARAMETERS
//  ADDR_W     8   memory address width (256 words)
//  DATA_W     16  memory word width
//  MAX_BURST  4   max consecutive transfers per grant while the other port waits (>=1)
// PORTS
//  ck          in   1       system clock, all flops on rising edge
//  rst         in   1       asynchronous reset, active-low (0 = reset)
//  a_req       in   1       port A requests memory (held until done)
//  a_we        in   1       port A write (1) / read (0)
//  a_addr      in   ADDR_W  port A address
//  a_wdata     in   DATA_W  port A write data
//  a_gnt       out  1       port A owns memory this cycle
//  a_rdata     out  DATA_W  read data to A (valid when a_gnt & ~a_we)
//  b_req/b_we/b_addr/b_wdata/b_gnt/b_rdata  same as A, for port B
//  mem_ce      out  1       memory chip enable
//  mem_we      out  1       memory write enable (sampled by memory at ck rise)
//  mem_addr    out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data (combinational from mem_addr)
// BEHAVIOUR
//  - FSM states: IDLE, OWN_A, OWN_B; state, burst counter, last-owner pointer registered.
//  - Reset (rst=0, async): state=IDLE, a_gnt=b_gnt=0, mem_ce=mem_we=0, mem_addr=0,
//    mem_wdata=0, burst_cnt=0, last_owner=B (A wins first tie).
//  - Grant latency: req seen high at edge N in IDLE -> gnt high from N+1 (registered).
//  - Transfer occurs in every cycle with X_gnt=1 & X_req=1; mem_* mux combinationally
//    from granted port; mem_we = X_gnt & X_req & X_we; X_rdata = mem_rdata same cycle.
//  - Ungranted port: gnt=0, rdata=0; its inputs must not reach mem_*.
//  - IDLE: only A -> OWN_A; only B -> OWN_B; both -> port != last_owner.
//  - OWN_X: each transfer increments burst_cnt; release to IDLE-decision when
//    X_req drops, or when burst_cnt reaches MAX_BURST and other port requests.
//    On release with other port requesting, switch directly OWN_X -> OWN_Y (no idle
//    cycle); last_owner=X; burst_cnt cleared on every ownership change.
//  - burst_cnt saturates at MAX_BURST when other port idle (no wrap, grant kept).
//  - Simultaneous drop of X_req and rise of Y_req: hand over to Y next cycle.
//  - X_req dropping while gnt high: no transfer that cycle; mem_ce=mem_we=0.
//  - Reset mid-transfer: grants and mem_we drop immediately (async); partial burst discarded.
//  - Masters must hold req/we/addr/wdata stable until they see gnt for that transfer.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs a_cnt, b_cnt (16 bit each) counting completed
//    transfers per port, and wait_cnt (16 bit) counting cycles where a req was high but
//    its gnt low; all saturate at 16'hFFFF, cleared by reset.
//  ARB_STATS_EN undefined: no counters, no extra ports; behaviour otherwise identical.
// STRUCTURE
//  Package nano_mem_pkg: ADDR_W/DATA_W constants, typedef arb_state_t {IDLE,OWN_A,OWN_B},
//    typedef owner_t {OWNER_A,OWNER_B}, struct mem_req_t {we,addr,wdata}.
//  One sub-module: nano_arb_rr2 (2-way round-robin pick + burst counter); the
//  datapath mux and optional stats stay in nano_mem_arbiter.
// TESTING
//  1 Reset: rst=0 with a_req=1 -> a_gnt=0, mem_ce=0, mem_we=0; release -> a_gnt at next edge.
//  2 A alone: a_req read addr 9 (mem=16'h000A) -> a_gnt after 1 cycle, a_rdata=16'h000A, b_gnt=0.
//  3 Tie from reset: a_req=b_req=1 same edge -> A granted 4 transfers (MAX_BURST=4),
//    then B granted next cycle with no idle gap; alternates thereafter.
//  4 B write: b_we=1, addr 10, wdata 16'h0037, A idle -> mem[10]=16'h0037 after edge;
//    A read of addr 10 next returns 16'h0037.
//  5 Burst no contention: A holds req for 10 reads -> a_gnt stays high all 10, no handover.
//  6 Async reset mid-burst: assert rst=0 between edges during B write -> b_gnt, mem_we
//    fall immediately; no write lands; with ARB_STATS_EN counters read 0.

Source files
------------

// File: rtl/nano_mem_pkg.sv
// ---------------------------------------------------------------------------
// nano_mem_pkg
// Shared types and constants for the NanoCPU program/data memory arbiter.
//   ADDR_W / DATA_W : geometry of the single-port 256x16 memory
//   arb_state_t     : arbiter ownership state
//   owner_t         : last-owner pointer used to break request ties
//   mem_req_t       : one memory access as presented by a master
//   sat_inc16       : saturating 16-bit increment (statistics counters)
// ---------------------------------------------------------------------------
package nano_mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/nano_arb_rr2.sv
// ---------------------------------------------------------------------------
// nano_arb_rr2
// Two-way round-robin arbiter with a bounded burst lock.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | nobody owns memory; next owner picked from requests/last owner
//   OWN_A  | port A owns memory, burst counter tracks its transfers
//   OWN_B  | port B owns memory, burst counter tracks its transfers
//
// Ports
//   ck_i     in   clock, rising edge
//   rst_n_i  in   asynchronous reset, active-low
//   a_req_i  in   port A request
//   b_req_i  in   port B request
//   a_gnt_o  out  port A owns memory this cycle
//   b_gnt_o  out  port B owns memory this cycle
// ---------------------------------------------------------------------------
module nano_arb_rr2
    import nano_mem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic ck_i,
    input  logic rst_n_i,
    input  logic a_req_i,
    input  logic b_req_i,
    output logic a_gnt_o,
    output logic b_gnt_o
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_t       state_q, state_d;
    owner_t           last_q, last_d;
    logic [CNT_W-1:0] burst_q, burst_d;

    logic             own_req;
    logic             oth_req;
    logic [CNT_W-1:0] burst_inc;

    always_ff @(posedge ck_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            last_q  <= OWNER_B;   // A wins the first tie after reset
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    always_comb begin
        own_req   = (state_q == OWN_A) ? a_req_i : b_req_i;
        oth_req   = (state_q == OWN_A) ? b_req_i : a_req_i;
        // Saturates so an uncontended owner keeps its grant indefinitely.
        burst_inc = (burst_q == CNT_MAX) ? burst_q : burst_q + CNT_W'(1);
        state_d   = state_q;
        last_d    = last_q;
        burst_d   = burst_q;
        case (state_q)
            IDLE: begin
                burst_d = '0;
                if (a_req_i && (!b_req_i || (last_q == OWNER_B))) begin
                    state_d = OWN_A;
                end else if (b_req_i) begin
                    state_d = OWN_B;
                end
            end
            OWN_A, OWN_B: begin
                if (own_req && !((burst_inc == CNT_MAX) && oth_req)) begin
                    burst_d = burst_inc;
                end else begin
                    // Release: hand straight to the other port if it waits.
                    burst_d = '0;
                    last_d  = (state_q == OWN_A) ? OWNER_A : OWNER_B;
                    if (oth_req) begin
                        state_d = (state_q == OWN_A) ? OWN_B : OWN_A;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                burst_d = '0;
            end
        endcase
    end

    always_comb begin
        a_gnt_o = (state_q == OWN_A);
        b_gnt_o = (state_q == OWN_B);
    end

endmodule

// File: rtl/nano_mem_arbiter.sv
// ---------------------------------------------------------------------------
// nano_mem_arbiter
// Shares the single-port 256x16 program/data memory between port A (NanoCPU)
// and port B (loader/debug/DMA). Grants are registered; the memory interface
// is muxed combinationally from the granted port while it requests.
//
// Ports
//   ck, rst                  clock (rising edge), async reset active-low
//   a_req/a_we/a_addr/a_wdata port A request, write flag, address, data
//   a_gnt, a_rdata           port A grant and read data
//   b_*                      same set for port B
//   mem_ce/mem_we            memory chip enable / write enable
//   mem_addr/mem_wdata       memory address / write data
//   mem_rdata                memory read data (combinational from mem_addr)
//   a_cnt/b_cnt/wait_cnt     transfer and wait counters (ARB_STATS_EN only)
//
// Build option
//   ARB_STATS_EN : adds saturating 16-bit statistics counters and their ports.
// ---------------------------------------------------------------------------
module nano_mem_arbiter
    import nano_mem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]       a_cnt,
    output logic [15:0]       b_cnt,
    output logic [15:0]       wait_cnt
`endif
);

    logic     a_xfer;
    logic     b_xfer;
    mem_req_t sel;

    nano_arb_rr2 #(
        .MAX_BURST (MAX_BURST)
    ) u_rr (
        .ck_i    (ck),
        .rst_n_i (rst),
        .a_req_i (a_req),
        .b_req_i (b_req),
        .a_gnt_o (a_gnt),
        .b_gnt_o (b_gnt)
    );

    assign a_xfer = a_gnt & a_req;
    assign b_xfer = b_gnt & b_req;

    // Only an active transfer drives the memory bus; otherwise it rests at zero
    // so an ungranted master never leaks onto mem_*.
    always_comb begin
        sel = '0;
        if (a_xfer) begin
            sel = '{we: a_we, addr: a_addr, wdata: a_wdata};
        end else if (b_xfer) begin
            sel = '{we: b_we, addr: b_addr, wdata: b_wdata};
        end
    end

    assign mem_ce    = a_xfer | b_xfer;
    assign mem_we    = sel.we;
    assign mem_addr  = sel.addr;
    assign mem_wdata = sel.wdata;

    assign a_rdata = a_gnt ? mem_rdata : '0;
    assign b_rdata = b_gnt ? mem_rdata : '0;

`ifdef ARB_STATS_EN
    logic [15:0] a_cnt_q, a_cnt_d;
    logic [15:0] b_cnt_q, b_cnt_d;
    logic [15:0] wait_q, wait_d;

    always_comb begin
        a_cnt_d = sat_inc16(a_cnt_q, a_xfer);
        b_cnt_d = sat_inc16(b_cnt_q, b_xfer);
        // One count per cycle in which at least one master is held off.
        wait_d  = sat_inc16(wait_q, (a_req & ~a_gnt) | (b_req & ~b_gnt));
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
            wait_q  <= '0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
            wait_q  <= wait_d;
        end
    end

    assign a_cnt    = a_cnt_q;
    assign b_cnt    = b_cnt_q;
    assign wait_cnt = wait_q;
`endif

endmodule

// File: tb/tb_nano_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nano_mem_arbiter
// Directed arbitration scenarios followed by random two-master traffic
// checked against a memory scoreboard and a starvation bound.
// ---------------------------------------------------------------------------
module tb_nano_mem_arbiter;

    localparam int MAXB = 4;

    logic        ck;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [7:0]  a_addr, b_addr, mem_addr;
    logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic        a_gnt, b_gnt, mem_ce, mem_we;
`ifdef ARB_STATS_EN
    logic [15:0] a_cnt, b_cnt, wait_cnt;
`endif

    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];

    int   errors = 0;
    int   checks = 0;
    logic exp_a;
    logic a_x, b_x;
    int   a_wait, b_wait, a_gap, b_gap, n_a, n_b;

    nano_mem_arbiter #(
        .MAX_BURST (MAXB)
    ) dut (
        .ck        (ck),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rdata   (b_rdata),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .a_cnt     (a_cnt),
        .b_cnt     (b_cnt),
        .wait_cnt  (wait_cnt)
`endif
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Memory array behind the arbiter: async read, write at rising edge.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i + 1);
        forever begin
            @(posedge ck);
            if (mem_we) mem[mem_addr] = mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr];

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i + 1);
        rst = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'd9; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0;   b_wdata = '0;

        // Reset while A requests
        @(negedge ck);
        check("rst_a_gnt", a_gnt, 0);
        check("rst_b_gnt", b_gnt, 0);
        check("rst_mem_ce", mem_ce, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_a_rdata", a_rdata, 0);
        rst = 1'b1;
        #1 check("rel_a_gnt_wait", a_gnt, 0);

        // A alone reads addr 9
        @(posedge ck); #1;
        check("a_lat_gnt", a_gnt, 1);
        @(negedge ck);
        check("a_rd_rdata", a_rdata, 16'h000A);
        check("a_rd_b_gnt", b_gnt, 0);
        check("a_rd_b_rdata", b_rdata, 0);
        check("a_rd_ce", mem_ce, 1);
        check("a_rd_addr", mem_addr, 9);
        @(posedge ck); #1;
        a_req = 1'b0;
        @(negedge ck);
        check("drop_gnt_held", a_gnt, 1);
        check("drop_ce", mem_ce, 0);
        check("drop_we", mem_we, 0);
        @(posedge ck); #1;
        check("drop_idle", a_gnt, 0);

        // Tie straight out of reset: A first, MAXB transfers each, no gap
        rst = 1'b0;
        a_req = 1'b1; a_addr = 8'd20;
        b_req = 1'b1; b_addr = 8'd30; b_we = 1'b0;
        #1 rst = 1'b1;
        @(posedge ck); #1;
        for (int k = 0; k < 4 * MAXB; k++) begin
            @(negedge ck);
            exp_a = ((k / MAXB) % 2) == 0;
            check("tie_a_gnt", a_gnt, exp_a);
            check("tie_b_gnt", b_gnt, !exp_a);
            check("tie_addr", mem_addr, exp_a ? 20 : 30);
            @(posedge ck); #1;
        end
        a_req = 1'b0; b_req = 1'b0;
        @(posedge ck); #1;

        // B writes addr 10, then A reads it back
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'd10; b_wdata = 16'h0037;
        @(posedge ck); #1;
        @(negedge ck);
        check("bw_b_gnt", b_gnt, 1);
        check("bw_a_gnt", a_gnt, 0);
        check("bw_mem_we", mem_we, 1);
        check("bw_mem_addr", mem_addr, 10);
        check("bw_mem_wdata", mem_wdata, 16'h0037);
        @(posedge ck); #1;
        ref_mem[10] = 16'h0037;
        check("bw_landed", mem[10], 16'h0037);
        b_req = 1'b0; b_we = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'd10;
        @(negedge ck);
        check("bw_rel_ce", mem_ce, 0);
        @(posedge ck); #1;
        @(negedge ck);
        check("ar_a_gnt", a_gnt, 1);
        check("ar_rdata", a_rdata, 16'h0037);

        // Uncontended burst of 10 reads: grant never leaves A
        for (int k = 0; k < 10; k++) begin
            @(posedge ck); #1;
            a_addr = 8'(100 + 7 * k);
            @(negedge ck);
            check("burst_a_gnt", a_gnt, 1);
            check("burst_b_gnt", b_gnt, 0);
            check("burst_rdata", a_rdata, ref_mem[a_addr]);
        end

        // B arrives while A's counter is saturated: one more A, then B
        @(posedge ck); #1;
        a_addr = 8'd200;
        b_req = 1'b1; b_we = 1'b1; b_addr = 8'd50; b_wdata = 16'hBEEF;
        @(negedge ck);
        check("sat_a_last", a_gnt, 1);
        @(posedge ck); #1;
        @(negedge ck);
        check("sat_b_gnt", b_gnt, 1);
        check("sat_b_we", mem_we, 1);

        // Async reset in the middle of B's write
        #1 rst = 1'b0;
        #1;
        check("arst_b_gnt", b_gnt, 0);
        check("arst_a_gnt", a_gnt, 0);
        check("arst_mem_we", mem_we, 0);
        check("arst_mem_ce", mem_ce, 0);
        @(posedge ck); #1;
        check("arst_no_write", mem[50], ref_mem[50]);
`ifdef ARB_STATS_EN
        check("arst_a_cnt", a_cnt, 0);
        check("arst_b_cnt", b_cnt, 0);
        check("arst_wait_cnt", wait_cnt, 0);
`endif
        a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
        #3 rst = 1'b1;

        // Random two-master traffic
        a_wait = 0; b_wait = 0; a_gap = 0; b_gap = 0; n_a = 0; n_b = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge ck);
            check("rnd_excl", a_gnt & b_gnt, 0);
            a_x = a_gnt & a_req;
            b_x = b_gnt & b_req;
            if (a_x) begin
                n_a++;
                check("rnd_a_wait_bound", a_wait <= MAXB + 1, 1);
                a_wait = 0;
                check("rnd_a_ce", mem_ce, 1);
                check("rnd_a_addr", mem_addr, a_addr);
                check("rnd_a_we", mem_we, a_we);
                if (a_we) check("rnd_a_wdata", mem_wdata, a_wdata);
                else      check("rnd_a_rdata", a_rdata, ref_mem[a_addr]);
            end else if (a_req) begin
                a_wait++;
            end
            if (b_x) begin
                n_b++;
                check("rnd_b_wait_bound", b_wait <= MAXB + 1, 1);
                b_wait = 0;
                check("rnd_b_ce", mem_ce, 1);
                check("rnd_b_addr", mem_addr, b_addr);
                check("rnd_b_we", mem_we, b_we);
                if (b_we) check("rnd_b_wdata", mem_wdata, b_wdata);
                else      check("rnd_b_rdata", b_rdata, ref_mem[b_addr]);
            end else if (b_req) begin
                b_wait++;
            end
            if (!a_gnt) check("rnd_a_rdata_idle", a_rdata, 0);
            if (!b_gnt) check("rnd_b_rdata_idle", b_rdata, 0);
            if (!a_x && !b_x) begin
                check("rnd_idle_ce", mem_ce, 0);
                check("rnd_idle_we", mem_we, 0);
            end
            @(posedge ck); #1;
            if (a_x && a_we) ref_mem[a_addr] = a_wdata;
            if (b_x && b_we) ref_mem[b_addr] = b_wdata;
            if (a_x || !a_req) begin
                if (a_gap > 0) begin
                    a_gap--; a_req = 1'b0;
                end else if ($urandom_range(0, 3) != 0) begin
                    a_req = 1'b1; a_we = 1'($urandom_range(0, 1));
                    a_addr = 8'($urandom_range(0, 255)); a_wdata = 16'($urandom);
                end else begin
                    a_req = 1'b0; a_gap = $urandom_range(0, 3);
                end
            end
            if (b_x || !b_req) begin
                if (b_gap > 0) begin
                    b_gap--; b_req = 1'b0;
                end else if ($urandom_range(0, 3) != 0) begin
                    b_req = 1'b1; b_we = 1'($urandom_range(0, 1));
                    b_addr = 8'($urandom_range(0, 255)); b_wdata = 16'($urandom);
                end else begin
                    b_req = 1'b0; b_gap = $urandom_range(0, 3);
                end
            end
        end
        check("rnd_a_final_wait", a_wait <= MAXB + 1, 1);
        check("rnd_b_final_wait", b_wait <= MAXB + 1, 1);
        check("rnd_a_progress", n_a > 0, 1);
        check("rnd_b_progress", n_b > 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
